// File: rtl/debouncer.sv
// Key debouncer with input synchronizer, sample-qualified state and press-event pulse.
// Optional feature: define DEBOUNCER_RELEASE_PULSE_EN to add the NE release-event output.
module debouncer #(
  parameter int unsigned STABLE_CNT  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic CLR,
  input  logic CEI,
  input  logic PUSH,
  output logic PE
`ifdef DEBOUNCER_RELEASE_PULSE_EN
  ,
  output logic NE
`endif
);

  localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   r_deb;
  logic                   r_deb_d;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_deb_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_pe;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign PE     = r_pe;

  // Synchronizer chain, shifts every clock regardless of the sample enable
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], PUSH};
    end
  end

  // Qualification: count consecutive differing samples, any agreeing sample restarts
  always_comb begin
    w_deb_nxt = r_deb;
    w_cnt_nxt = r_cnt;
    if (CEI) begin
      if (w_sync == r_deb) begin
        w_cnt_nxt = '0;
      end else if (r_cnt == CNT_LAST) begin
        w_deb_nxt = w_sync;
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + CNT_ONE;
      end
    end
  end

  // Debounced state, sample counter and one-cycle-delayed copy for edge detection
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_deb   <= 1'b0;
      r_cnt   <= '0;
      r_deb_d <= 1'b0;
    end else begin
      r_deb   <= w_deb_nxt;
      r_cnt   <= w_cnt_nxt;
      r_deb_d <= r_deb;
    end
  end

  // Press pulse lands on the edge after the debounced state rises
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_pe <= 1'b0;
    end else begin
      r_pe <= r_deb & ~r_deb_d;
    end
  end

`ifdef DEBOUNCER_RELEASE_PULSE_EN
  logic r_ne;

  assign NE = r_ne;

  // Release pulse lands on the edge after the debounced state falls
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_ne <= 1'b0;
    end else begin
      r_ne <= ~r_deb & r_deb_d;
    end
  end
`endif

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for debouncer: STABLE_CNT=4/SYNC_STAGES=2 main instance, STABLE_CNT=1/SYNC_STAGES=3 side instance.
`timescale 1ns/1ps
module tb_debouncer;

  logic CLK;
  logic CLR;
  logic CEI;
  logic PUSH;
  logic PE;
  logic PE1;
`ifdef DEBOUNCER_RELEASE_PULSE_EN
  logic NE;
  logic NE1;
`endif

  int errors;
  int checks;
  int tick_no;
  int pe_cnt;
  int pe_first;
  int pe1_cnt;
  int pe1_first;
  int ne_cnt;
  int ne_first;

  debouncer #(.STABLE_CNT(4), .SYNC_STAGES(2)) dut (
    .CLK  (CLK),
    .CLR  (CLR),
    .CEI  (CEI),
    .PUSH (PUSH),
    .PE   (PE)
`ifdef DEBOUNCER_RELEASE_PULSE_EN
    ,
    .NE   (NE)
`endif
  );

  debouncer #(.STABLE_CNT(1), .SYNC_STAGES(3)) dut1 (
    .CLK  (CLK),
    .CLR  (CLR),
    .CEI  (CEI),
    .PUSH (PUSH),
    .PE   (PE1)
`ifdef DEBOUNCER_RELEASE_PULSE_EN
    ,
    .NE   (NE1)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    tick_no   = 0;
    pe_cnt    = 0;
    pe_first  = 0;
    pe1_cnt   = 0;
    pe1_first = 0;
    ne_cnt    = 0;
    ne_first  = 0;
  endtask

  // Drive inputs for the next rising edge, then observe 1 ns after it
  task automatic tick(input logic push, input logic cei);
    PUSH = push;
    CEI  = cei;
    @(posedge CLK);
    #1;
    tick_no++;
    if (PE) begin
      pe_cnt++;
      if (pe_first == 0) pe_first = tick_no;
    end
    if (PE1) begin
      pe1_cnt++;
      if (pe1_first == 0) pe1_first = tick_no;
    end
`ifdef DEBOUNCER_RELEASE_PULSE_EN
    if (NE) begin
      ne_cnt++;
      if (ne_first == 0) ne_first = tick_no;
    end
`endif
  endtask

  task automatic do_reset();
    CLR = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    CLR = 1'b1;
    clear_counts();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    CLR  = 1'b0;
    CEI  = 1'b0;
    PUSH = 1'b0;
    clear_counts();

    // Reset held with key pressed and CEI toggling
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, (i % 2) == 1);
      chk("rst_pe",   32'(PE), 0);
      chk("rst_deb",  32'(dut.r_deb), 0);
      chk("rst_cnt",  32'(dut.r_cnt), 0);
      chk("rst_sync", 32'(dut.r_sync), 0);
    end
    // Key held through reset needs full qualification after release
    CLR = 1'b1;
    clear_counts();
    for (int i = 1; i <= 20; i++) begin
      tick(1'b1, 1'b1);
      if (i == 5) chk("held_deb_t5", 32'(dut.r_deb), 0);
      if (i == 6) chk("held_deb_t6", 32'(dut.r_deb), 1);
    end
    chk("held_pe_first",  pe_first, 7);
    chk("held_pe_cnt",    pe_cnt, 1);
    chk("s1_pe_first",    pe1_first, 5);
    chk("s1_pe_cnt",      pe1_cnt, 1);

    // Clean press, CEI once every 16 clocks
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      tick(1'b1, (i % 16) == 0);
      if (i == 48) chk("clean_cnt_t48", 32'(dut.r_cnt), 3);
    end
    chk("clean_pe_first", pe_first, 65);
    chk("clean_pe_cnt",   pe_cnt, 1);
    chk("clean_deb",      32'(dut.r_deb), 1);

    // Bouncing press: samples 1,0,1,1,1,1 at CEI every 4 clocks
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      tick((i >= 10) || (i == 1) || (i == 2) || (i == 4) || (i == 7) || (i == 9), (i % 4) == 0);
      if (i == 4)  chk("bnc_cnt_t4",  32'(dut.r_cnt), 1);
      if (i == 8)  chk("bnc_cnt_t8",  32'(dut.r_cnt), 0);
      if (i == 20) chk("bnc_cnt_t20", 32'(dut.r_cnt), 3);
      if (i == 20) chk("bnc_pe_t20",  32'(PE), 0);
    end
    chk("bnc_pe_first", pe_first, 25);
    chk("bnc_pe_cnt",   pe_cnt, 1);
    chk("bnc_deb",      32'(dut.r_deb), 1);
    chk("s1_bnc_pe_cnt", pe1_cnt, 2);

    // Release after the press: no PE, optional NE
    clear_counts();
    for (int i = 1; i <= 12; i++) begin
      tick(1'b0, 1'b1);
      if (i == 5) chk("rel_deb_t5", 32'(dut.r_deb), 1);
      if (i == 6) chk("rel_deb_t6", 32'(dut.r_deb), 0);
    end
    chk("rel_pe_cnt", pe_cnt, 0);
`ifdef DEBOUNCER_RELEASE_PULSE_EN
    chk("rel_ne_first", ne_first, 7);
    chk("rel_ne_cnt",   ne_cnt, 1);
`endif

    // Glitch while CEI is low is never sampled
    do_reset();
    for (int i = 1; i <= 25; i++) begin
      tick(i <= 3, i >= 6);
      if (i == 5) chk("glt_cnt_t5", 32'(dut.r_cnt), 0);
    end
    chk("glt_pe_cnt", pe_cnt, 0);
    chk("glt_deb",    32'(dut.r_deb), 0);

    // Reset in the middle of qualification
    do_reset();
    for (int i = 1; i <= 4; i++) tick(1'b1, 1'b1);
    chk("mid_cnt_pre", 32'(dut.r_cnt), 2);
    CLR = 1'b0;
    #1;
    chk("mid_cnt_async",  32'(dut.r_cnt), 0);
    chk("mid_sync_async", 32'(dut.r_sync), 0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    CLR = 1'b1;
    clear_counts();
    for (int i = 1; i <= 12; i++) tick(1'b1, 1'b1);
    chk("mid_pe_first", pe_first, 7);
    chk("mid_pe_cnt",   pe_cnt, 1);

    // Reset while PE is high clears it and no pulse follows
    do_reset();
    for (int i = 1; i <= 7; i++) tick(1'b1, 1'b1);
    chk("pulse_pe_hi", 32'(PE), 1);
    CLR = 1'b0;
    #1;
    chk("pulse_pe_async", 32'(PE), 0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    CLR = 1'b1;
    clear_counts();
    for (int i = 1; i <= 15; i++) tick(1'b0, 1'b1);
    chk("pulse_no_regen", pe_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
